// File: rtl/fpu_mul_pkg.sv
// ============================================================================
//  Module      : fpu_mul_pkg
//  Description : Shared constants and stage-partition helper for the
//                pipelined fraction multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_mul_pkg;

    localparam int c_MUL_WIDTH  = 26;
    localparam int c_MUL_STAGES = 6;

    // Lowest multiplier bit handled by stage j (1-based); stage j ends one
    // bit below stage_lo(j+1), so consecutive calls tile the multiplier.
    function automatic int stage_lo(input int j, input int width, input int stages);
        return ((j - 1) * width) / stages;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_stage.sv
// ============================================================================
//  Module      : mul_stage
//  Description : Combinational shift-and-add slice covering multiplier bits
//                LO..HI of one pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_stage #(
    parameter int WIDTH = 26,
    parameter int LO    = 0,
    parameter int HI    = 0
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [HI:LO]       b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] w_a_ext;

    assign w_a_ext = {{WIDTH{1'b0}}, a_i};

    always_comb begin
        acc_o = acc_i;
        for (int k = LO; k <= HI; k++) begin
            if (b_i[k]) begin
                acc_o = acc_o + (w_a_ext << k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_frac_pipe.sv
// ============================================================================
//  Module      : mul_frac_pipe
//  Description : STAGES-deep pipelined unsigned fraction multiplier returning
//                upper product bits plus guard/sticky for rounding.
//                Optional output normalization: define MUL_NORM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_frac_pipe
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH  = c_MUL_WIDTH,
    parameter int STAGES = c_MUL_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] prod_hi,
    output logic             guard,
    output logic             sticky,
    output logic             norm_shift
);

    localparam int c_PW = 2 * WIDTH;

    logic [c_PW-1:0]   acc_q    [STAGES];
    logic [c_PW-1:0]   acc_d    [STAGES];
    logic [WIDTH-1:0]  a_q      [STAGES];
    logic [WIDTH-1:0]  b_q      [STAGES];
    logic [STAGES-1:0] valid_q;

    logic [c_PW-1:0]   w_acc_in [STAGES];
    logic [WIDTH-1:0]  w_a_in   [STAGES];
    logic [WIDTH-1:0]  w_b_in   [STAGES];
    logic [STAGES-1:0] w_v_in;
    logic [c_PW-1:0]   w_p;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_LO = stage_lo(s + 1, WIDTH, STAGES);
        localparam int c_HI = stage_lo(s + 2, WIDTH, STAGES) - 1;

        if (s == 0) begin : g_first
            assign w_acc_in[s] = '0;
            assign w_a_in[s]   = a;
            assign w_b_in[s]   = b;
            assign w_v_in[s]   = in_valid;
        end else begin : g_next
            assign w_acc_in[s] = acc_q[s-1];
            assign w_a_in[s]   = a_q[s-1];
            assign w_b_in[s]   = b_q[s-1];
            assign w_v_in[s]   = valid_q[s-1];
        end

        mul_stage #(
            .WIDTH (WIDTH),
            .LO    (c_LO),
            .HI    (c_HI)
        ) u_stage (
            .acc_i (w_acc_in[s]),
            .a_i   (w_a_in[s]),
            .b_i   (w_b_in[s][c_HI:c_LO]),
            .acc_o (acc_d[s])
        );
    end

    // Asynchronous clear flushes every in-flight operation, valids included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                acc_q[s] <= '0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                acc_q[s] <= acc_d[s];
                a_q[s]   <= w_a_in[s];
                b_q[s]   <= w_b_in[s];
            end
            valid_q <= w_v_in;
        end
    end

    assign w_p       = acc_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];

    always_comb begin
        prod_hi    = w_p[c_PW-1:WIDTH];
        guard      = w_p[WIDTH-1];
        sticky     = |w_p[WIDTH-2:0];
        norm_shift = 1'b0;
`ifdef MUL_NORM_EN
        // Product of two [1,2) mantissas lies in [1,4); realign the [1,2) case.
        if (!w_p[c_PW-1] && (|w_p)) begin
            prod_hi    = w_p[c_PW-2:WIDTH-1];
            guard      = w_p[WIDTH-2];
            sticky     = |w_p[WIDTH-3:0];
            norm_shift = 1'b1;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_frac_pipe.sv
// ============================================================================
//  Module      : tb_mul_frac_pipe
//  Description : Scoreboard bench driving four multiplier instances
//                (STAGES = 6, 1, 13, 26) from one shared operand stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_frac_pipe;

    localparam int W  = 26;
    localparam int ND = 4;

    typedef struct {
        logic [W-1:0] hi;
        logic         g;
        logic         s;
        logic         n;
        int           due;
    } exp_t;

    function automatic int st_of(input int i);
        case (i)
            0:       return 6;
            1:       return 1;
            2:       return 13;
            default: return 26;
        endcase
    endfunction

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;

    // Hand-computed expectation attached to the operation being driven.
    logic         h_en = 1'b0;
    logic [W-1:0] h_hi = '0;
    logic         h_g  = 1'b0;
    logic         h_s  = 1'b0;
    logic         h_n  = 1'b0;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    logic [ND-1:0] ov;
    logic [ND-1:0] og;
    logic [ND-1:0] os;
    logic [ND-1:0] on;
    logic [W-1:0]  ohi [ND];

    exp_t q [ND][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        mul_frac_pipe #(
            .WIDTH  (W),
            .STAGES (st_of(i))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .a          (a),
            .b          (b),
            .out_valid  (ov[i]),
            .prod_hi    (ohi[i]),
            .guard      (og[i]),
            .sticky     (os[i]),
            .norm_shift (on[i])
        );
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
        exp_t           m;
        logic [2*W-1:0] p;
        p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        m.hi  = p[2*W-1:W];
        m.g   = p[W-1];
        m.s   = |p[W-2:0];
        m.n   = 1'b0;
        m.due = due;
`ifdef MUL_NORM_EN
        if (!p[2*W-1] && p != '0) begin
            m.hi = p[2*W-2:W-1];
            m.g  = p[W-2];
            m.s  = |p[W-3:0];
            m.n  = 1'b1;
        end
`endif
        return m;
    endfunction

    // Scoreboard producer: every accepted operation queues its expected result.
    always @(posedge clk) begin : sampler
        exp_t t;
        if (rst && in_valid) begin
            for (int i = 0; i < ND; i++) begin
                t = model(a, b, cyc + st_of(i));
                if (h_en) begin
                    t.hi = h_hi;
                    t.g  = h_g;
                    t.s  = h_s;
                    t.n  = h_n;
                end
                q[i].push_back(t);
            end
        end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic ev;
        for (int i = 0; i < ND; i++) begin
            if (!rst) begin
                checks = checks + 1;
                if (ov[i] !== 1'b0 || ohi[i] !== '0 || og[i] !== 1'b0 || os[i] !== 1'b0 || on[i] !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL reset_zero S=%0d: got v=%b hi=%h g=%b s=%b n=%b, want all 0",
                             st_of(i), ov[i], ohi[i], og[i], os[i], on[i]);
                end
                q[i].delete();
            end else begin
                ev = (q[i].size() > 0) && (q[i][0].due == cyc);
                checks = checks + 1;
                if (ov[i] !== ev) begin
                    failures = failures + 1;
                    $display("FAIL out_valid S=%0d cyc=%0d: got %b, want %b", st_of(i), cyc, ov[i], ev);
                end
                if (ev) begin
                    e = q[i].pop_front();
                    if (ov[i] === 1'b1) begin
                        checks = checks + 1;
                        if (ohi[i] !== e.hi || og[i] !== e.g || os[i] !== e.s || on[i] !== e.n) begin
                            failures = failures + 1;
                            $display("FAIL data S=%0d cyc=%0d: got hi=%h g=%b s=%b n=%b, want hi=%h g=%b s=%b n=%b",
                                     st_of(i), cyc, ohi[i], og[i], os[i], on[i], e.hi, e.g, e.s, e.n);
                        end
                    end
                end
            end
        end
    end

    task automatic send_h(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ehi, input logic eg, input logic es, input logic en);
        @(negedge clk);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        h_en     = 1'b1;
        h_hi     = ehi;
        h_g      = eg;
        h_s      = es;
        h_n      = en;
    endtask

    task automatic send_r();
        @(negedge clk);
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        h_en     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            h_en     = 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        idle(2);

`ifdef MUL_NORM_EN
        send_h(26'h2000000, 26'h2000000, 26'h2000000, 1'b0, 1'b0, 1'b1);
        idle(30);
        send_h(26'h2000000, 26'h3000000, 26'h3000000, 1'b0, 1'b0, 1'b1);
        send_h(26'h2000001, 26'h2000000, 26'h2000001, 1'b0, 1'b0, 1'b1);
        send_h(26'h0000001, 26'h0000001, 26'h0000000, 1'b0, 1'b1, 1'b1);
`else
        send_h(26'h2000000, 26'h2000000, 26'h1000000, 1'b0, 1'b0, 1'b0);
        idle(30);
        send_h(26'h2000000, 26'h3000000, 26'h1800000, 1'b0, 1'b0, 1'b0);
        send_h(26'h2000001, 26'h2000000, 26'h1000000, 1'b1, 1'b0, 1'b0);
        send_h(26'h0000001, 26'h0000001, 26'h0000000, 1'b0, 1'b1, 1'b0);
`endif
        send_h(26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFE, 1'b0, 1'b1, 1'b0);
        send_h(26'h0000000, 26'h3FFFFFF, 26'h0000000, 1'b0, 1'b0, 1'b0);
        send_h(26'h3000000, 26'h3000000, 26'h2400000, 1'b0, 1'b0, 1'b0);
        idle(30);

        // Ten back-to-back operations followed by three bubbles.
        repeat (10) send_r();
        idle(3);
        idle(30);

        // Reset mid-flight, then a fresh operation after release.
        repeat (4) send_r();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        idle(10);
        send_h(26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFE, 1'b0, 1'b1, 1'b0);
        idle(30);

        // Long random stream with occasional bubbles.
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 7) != 0) send_r();
            else                           idle(1);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
